// File: rtl/rand_unpack_if.sv
// PRNG word channel between the SHAKE/AES PRNG and the unpacker.
//   in_data  : PRNG word
//   in_valid : in_data valid (the PRNG drives it and holds the word until it is accepted)
//   in_ready : unpacker takes in_data on this edge when in_valid is also high
// Modports:
//   master : PRNG side
//   slave  : unpacker side
interface rand_unpack_if #(
  parameter int IN_W = 64
) ();
  logic [IN_W-1:0] in_data;
  logic            in_valid;
  logic            in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/rand_unpack.sv
// rand_unpack: upstream feeder for the Gaussian sampler.
// The block takes IN_W-bit PRNG words and splits each word into OUT_W-bit lanes.
// It emits one lane per cycle and stops after exactly num_samples lanes per job.
// When the job ends, any lanes still left in the last word are discarded.
//
// Ports:
//   clk, rst_n    : clock; rst_n is a synchronous, ACTIVE-HIGH reset
//   start         : one-cycle job start pulse (ignored unless idle)
//   num_samples   : number of lanes for this job, sampled on start
//   prng          : word channel (rand_unpack_if.slave)
//   random_string : registered lane to the sampler
//   en            : registered strobe, high when random_string carries a new lane
//   busy          : high while a job is in progress (RUN or FLUSH)
//   done          : one-cycle pulse on the cycle after the last lane
//
// Build option: when RAND_UNPACK_MSB_FIRST_EN is defined, lane 0 is taken from the top
// of the word (big-endian PRNG). Otherwise lane 0 is taken from the bottom.
module rand_unpack #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 16,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  rand_unpack_if.slave      prng,
  output logic [OUT_W-1:0]  random_string,
  output logic              en,
  output logic              busy,
  output logic              done
);
  localparam int NUM_LANES = IN_W / OUT_W;
  localparam int LANE_W    = $clog2(NUM_LANES);
  localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(NUM_LANES - 1);
  localparam logic [CNT_W-1:0]  WORD_LANES = CNT_W'(NUM_LANES);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [IN_W-1:0]         buf_q, buf_d;
  logic                    buf_full_q, buf_full_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic [CNT_W-1:0]        emit_rem_q, emit_rem_d;  // lanes still to present
  logic [CNT_W-1:0]        load_rem_q, load_rem_d;  // lanes still to fetch from the PRNG
  logic [OUT_W-1:0]        rs_q, rs_d;
  logic                    en_q, en_d;
  logic                    done_q, done_d;

  logic [NUM_LANES-1:0][OUT_W-1:0] lanes;
  logic in_ready, accept, emit;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
`ifdef RAND_UNPACK_MSB_FIRST_EN
    assign lanes[i] = buf_q[(NUM_LANES-1-i)*OUT_W +: OUT_W];
`else
    assign lanes[i] = buf_q[i*OUT_W +: OUT_W];
`endif
  end

  // A new word may be accepted while the last lane of the current word is going out.
  // This allows back-to-back words with no bubble on en.
  assign in_ready = (state_q == RUN) && (load_rem_q != '0) &&
                    (!buf_full_q || (lane_q == LAST_LANE && emit_rem_q != '0));
  assign accept   = prng.in_valid && in_ready;
  assign emit     = (state_q == RUN) && buf_full_q && (emit_rem_q != '0);

  assign prng.in_ready = in_ready;
  assign random_string = rs_q;
  assign en            = en_q;
  assign done          = done_q;
  assign busy          = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    lane_d     = lane_q;
    emit_rem_d = emit_rem_q;
    load_rem_d = load_rem_q;
    rs_d       = rs_q;
    en_d       = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          emit_rem_d = num_samples;
          load_rem_d = num_samples;
          state_d    = (num_samples == '0) ? FLUSH : RUN;
        end
      end
      RUN: begin
        if (emit) begin
          rs_d       = lanes[lane_q];
          en_d       = 1'b1;
          emit_rem_d = emit_rem_q - CNT_W'(1);
          lane_d     = lane_q + LANE_W'(1);
          if (lane_q == LAST_LANE) buf_full_d = 1'b0;
        end
        // Accept overrides the end-of-word clear.
        if (accept) begin
          buf_d      = prng.in_data;
          buf_full_d = 1'b1;
          lane_d     = '0;
          load_rem_d = (load_rem_q >= WORD_LANES) ? load_rem_q - WORD_LANES : '0;
        end
        // After the final lane, any lanes still in the buffer are discarded.
        if (emit && emit_rem_q == CNT_W'(1)) begin
          state_d    = FLUSH;
          buf_full_d = 1'b0;
        end
      end
      FLUSH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      lane_q     <= '0;
      emit_rem_q <= '0;
      load_rem_q <= '0;
      rs_q       <= '0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      lane_q     <= lane_d;
      emit_rem_q <= emit_rem_d;
      load_rem_q <= load_rem_d;
      rs_q       <= rs_d;
      en_q       <= en_d;
      done_q     <= done_d;
    end
  end
endmodule

// File: tb/tb_rand_unpack.sv
// Scoreboard bench for rand_unpack. The expected lanes of each job are the first
// num_samples lanes of the offered word list, in lane order. They are queued when the
// job starts. A monitor pops one expected lane per en cycle and compares it.
module tb_rand_unpack;
  localparam int IN_W = 64, OUT_W = 16, CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_samples = '0;
  logic [OUT_W-1:0] random_string;
  logic             en, busy, done;

  rand_unpack_if #(.IN_W(IN_W)) prng ();

  rand_unpack #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .prng(prng), .random_string(random_string), .en(en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic [IN_W-1:0]  drv_words[$];
  logic [IN_W-1:0]  job_words[$];
  int drv_mode = 0, drv_idx = 0, accepts = 0;
  int en_cnt = 0, first_en = -1, last_en = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Lane k of word w, computed by plain shifting.
  function automatic logic [OUT_W-1:0] model_lane(input logic [IN_W-1:0] w, input int k);
`ifdef RAND_UNPACK_MSB_FIRST_EN
    return OUT_W'(w >> (OUT_W * (3 - k)));
`else
    return OUT_W'(w >> (OUT_W * k));
`endif
  endfunction

  // PRNG model. The current word is presented at each negedge.
  // A word counts as accepted when valid and ready are both high just before the posedge.
  // mode 0: valid held high; mode 1: random valid; mode 2: valid pattern 1,0,0,1.
  initial begin
    prng.in_valid = 1'b0;
    prng.in_data  = '0;
    forever begin
      @(negedge clk);
      if (drv_words.size() > 0) begin
        prng.in_data = drv_words[0];
        case (drv_mode)
          0:       prng.in_valid = 1'b1;
          1:       prng.in_valid = 1'($urandom_range(0, 1));
          default: prng.in_valid = (drv_idx % 4 == 0) || (drv_idx % 4 == 3);
        endcase
        drv_idx++;
      end else begin
        prng.in_valid = 1'b0;
      end
      #1;
      if (prng.in_valid && prng.in_ready) begin
        accepts++;
        void'(drv_words.pop_front());
      end
    end
  end

  // Monitor: every en cycle must carry the next expected lane.
  initial forever begin
    @(negedge clk);
    if (en === 1'b1) begin
      en_cnt++;
      if (first_en < 0) first_en = cyc;
      last_en = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL lane_unexpected: got %0h, expected no en", random_string);
      end else begin
        check("lane_data", random_string, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic run_job(input int n, input int mode, input bit mid_start);
    int st, nw;
    bit got;
    nw = (n + 3) / 4;
    for (int k = 0; k < n; k++) exp_q.push_back(model_lane(job_words[k / 4], k % 4));
    accepts = 0; en_cnt = 0; first_en = -1; last_en = -1;
    drv_idx = 0; drv_mode = mode; drv_words = job_words;
    tick();
    start = 1'b1; num_samples = CNT_W'(n); st = cyc;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (done === 1'b1) got = 1'b1;
      else begin
        // a start pulse in the middle of a job must have no effect
        start = mid_start && (i == 6);
        num_samples = CNT_W'(3);
        tick();
      end
    end
    start = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done, expected done for n=%0d", n);
    end else begin
      check("accepts", accepts, nw);
      check("en_count", en_cnt, n);
      check("lanes_left", exp_q.size(), 0);
      check("busy_at_done", busy, 1'b0);
      check("in_ready_at_done", prng.in_ready, 1'b0);
      if (n == 0) check("done_latency_zero", cyc - st, 2);
      else check("done_after_last_en", cyc - last_en, 1);
      if (mode == 0 && n > 0) begin
        check("first_lane_latency", first_en - st, 3);
        check("en_no_gaps", last_en - first_en, n - 1);
      end
      tick();
      check("done_one_cycle", done, 1'b0);
    end
    drv_words.delete();
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [IN_W-1:0] w;
    int n, nd;
    repeat (3) tick();
    rst_n = 1'b0;
    check("rst_en", en, 1'b0);
    check("rst_rs", random_string, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_in_ready", prng.in_ready, 1'b0);

    // one word, four lanes
    job_words = '{64'h4444_3333_2222_1111, 64'hdead_beef_0bad_f00d};
    run_job(4, 0, 1'b0);
    // two back-to-back words
    job_words = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
    run_job(8, 0, 1'b0);
    // surplus lanes of the last word are dropped
    job_words = '{64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, 64'h1234_5678_9abc_def0};
    run_job(6, 0, 1'b0);
    // empty job
    job_words = '{64'h1111_2222_3333_4444};
    run_job(0, 0, 1'b0);
    // gappy valid plus an ignored mid-job start
    job_words = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
    run_job(8, 2, 1'b1);

    // reset in the middle of a job
    job_words = '{64'haaaa_bbbb_cccc_dddd, 64'h1111_2222_3333_4444};
    for (int k = 0; k < 8; k++) exp_q.push_back(model_lane(job_words[k / 4], k % 4));
    en_cnt = 0; first_en = -1; drv_idx = 0; drv_mode = 0; drv_words = job_words;
    tick();
    start = 1'b1; num_samples = CNT_W'(8);
    tick();
    start = 1'b0;
    for (int i = 0; i < 50 && en_cnt < 2; i++) tick();
    check("lanes_before_reset", en_cnt, 2);
    rst_n = 1'b1;
    drv_words.delete();
    tick();
    rst_n = 1'b0;
    check("mid_rst_en", en, 1'b0);
    check("mid_rst_rs", random_string, '0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_in_ready", prng.in_ready, 1'b0);
    exp_q.delete();
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1) nd++;
    end
    check("no_done_after_reset", nd, 0);
    job_words = '{64'h4444_3333_2222_1111};
    run_job(4, 0, 1'b0);

    // randomized jobs
    for (int j = 0; j < 10; j++) begin
      n = $urandom_range(1, 14);
      job_words.delete();
      for (int k = 0; k < (n + 3) / 4 + 1; k++) begin
        w = {$urandom, $urandom};
        job_words.push_back(w);
      end
      run_job(n, $urandom_range(0, 2), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
